display_framebuffer_writer: RTL and testbench

// - Captures a 16 bit RGB565 pixel stream (camera, video input, or display-loopback test source) into a framebuffer in memory.
// - Issues a stream-to-memory command header to the DmaStreamEngine st0 slave, then packs pixel pairs into 32 bit data beats behind it.
// - It is the write-side counterpart of the display framebuffer reader and is instantiated beside it on the same DSE.

---
 rtl/display_framebuffer_writer_pkg.sv | 37 +++
 rtl/display_framebuffer_writer_if.sv | 19 +
 rtl/display_framebuffer_writer_fb_pixel_packer.sv | 155 +++++++++++++++
 rtl/display_framebuffer_writer.sv | 126 ++++++++++++
 tb/tb_display_framebuffer_writer.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/display_framebuffer_writer_pkg.sv
// ---------------------------------------------------------------------------
// display_framebuffer_writer_pkg
// Shared DmaStreamEngine (DSE) definitions plus local widths and the writer
// FSM state type. The DSE opcode/mux constants and header layout are shared
// with the display framebuffer reader.
// No ports (package).
// ---------------------------------------------------------------------------
package display_framebuffer_writer_pkg;

   // DSE command header opcodes and stream mux selects
   localparam logic [1:0] DSE_OP_MEM_READ  = 2'h1;
   localparam logic [1:0] DSE_OP_MEM_WRITE = 2'h2;
   localparam logic [1:0] DSE_MUX_ST0      = 2'h3;

   // Header layout: [31:30] opcode, [29:28] stream mux, [27:0] byte length
   localparam int DSE_HDR_LEN_W = 28;

   localparam int DISPLAY_STREAM_WIDTH = 16;
   localparam int STREAM_WIDTH         = 32;
   localparam int ADDR_WIDTH           = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_ADDR = 2'd2,
      ST_DATA = 2'd3
   } fbw_state_e;

   function automatic logic [STREAM_WIDTH-1:0] dse_header(
      input logic [1:0]               op,
      input logic [1:0]               mux,
      input logic [DSE_HDR_LEN_W-1:0] len_bytes
   );
      return {op, mux, len_bytes};
   endfunction

endpackage

// File: rtl/display_framebuffer_writer_if.sv
// ---------------------------------------------------------------------------
// display_framebuffer_writer_if
// AXI-Stream style bundle used for both the RGB565 pixel input (DW=16) and
// the DSE st0 output (DW=32).
// Signals: tvalid, tready, tlast, tuser, tdata[DW-1:0]
// Modports: master (drives valid/last/user/data), slave (drives ready).
// ---------------------------------------------------------------------------
interface display_framebuffer_writer_if #(
   parameter int DW = 32
) ();
   logic          tvalid;
   logic          tready;
   logic          tlast;
   logic          tuser;
   logic [DW-1:0] tdata;

   modport master (output tvalid, output tlast, output tuser, output tdata, input  tready);
   modport slave  (input  tvalid, input  tlast, input  tuser, input  tdata, output tready);
endinterface

// File: rtl/display_framebuffer_writer_fb_pixel_packer.sv
// ---------------------------------------------------------------------------
// display_framebuffer_writer_fb_pixel_packer
// Packs 16 bit pixels into 32 bit beats (even pixel low half, odd pixel high
// half), counts beats so the frame length is always exact, flags tlast on the
// final beat and pads with zero pixels after a short frame.
// Optional feature macro: FB_WRITER_SOF_SYNC_EN (discard pixels until the
// first one with tuser=1; a later tuser=1 is handled as a short frame).
// Ports:
//   aclk, rst         clock, asynchronous active-high reset
//   en_i              high while the writer is in its DATA phase; low clears
//   pix_*_i/o         pixel stream slave side
//   beat_*_i/o        packed beat master side
//   short_o           pulse: frame ended early (pad started)
//   done_o            pulse: final beat handshaken
// ---------------------------------------------------------------------------
module display_framebuffer_writer_fb_pixel_packer
   import display_framebuffer_writer_pkg::*;
#(
   parameter int unsigned NUM_BEATS = 4
) (
   input  logic                            aclk,
   input  logic                            rst,
   input  logic                            en_i,
   input  logic                            pix_valid_i,
   output logic                            pix_ready_o,
   input  logic                            pix_last_i,
   input  logic                            pix_user_i,
   input  logic [DISPLAY_STREAM_WIDTH-1:0] pix_data_i,
   input  logic                            beat_ready_i,
   output logic                            beat_valid_o,
   output logic                            beat_last_o,
   output logic [STREAM_WIDTH-1:0]         beat_data_o,
   output logic                            short_o,
   output logic                            done_o
);

   localparam int CW = $clog2(NUM_BEATS + 1);
   localparam logic [CW-1:0] LAST_BEAT = CW'(NUM_BEATS - 1);
   localparam logic [CW-1:0] ALL_BEATS = CW'(NUM_BEATS);

   logic [CW-1:0]                   beat_cnt_q;   // beats formed so far
   logic                            have_low_q;   // skid: even pixel waiting for its pair
   logic [DISPLAY_STREAM_WIDTH-1:0] low_q;
   logic                            out_valid_q;
   logic                            out_last_q;
   logic [STREAM_WIDTH-1:0]         out_data_q;
   logic                            pad_q;

   logic                            room;
   logic                            more;
   logic                            take_ok;
   logic                            pix_hs;
   logic                            synced;
   logic                            sof_start;
   logic                            mid_sof;
   logic                            src_step;
   logic                            pad_step;
   logic                            step;
   logic                            final_pix;
   logic [DISPLAY_STREAM_WIDTH-1:0] step_data;
   logic                            beat_hs;

   // Room for one more pixel: low slot free, or the beat register free to
   // take the pair. Depends on registers only, so tready has no path from
   // the downstream tready.
   assign room    = !have_low_q || !out_valid_q;
   assign more    = (beat_cnt_q != ALL_BEATS);
   assign take_ok = en_i && room && more && !pad_q;
   assign pix_hs  = pix_valid_i && pix_ready_o;

`ifdef FB_WRITER_SOF_SYNC_EN
   logic synced_q;

   assign synced    = synced_q;
   assign sof_start = pix_hs && !synced_q && pix_user_i;
   assign mid_sof   = pix_hs && synced_q && pix_user_i;

   always_ff @(posedge aclk or posedge rst) begin
      if (rst) begin
         synced_q <= 1'b0;
      end else if (!en_i) begin
         synced_q <= 1'b0;
      end else if (sof_start) begin
         synced_q <= 1'b1;
      end
   end
`else
   logic unused_tuser;

   assign unused_tuser = pix_user_i;
   assign synced       = 1'b1;
   assign sof_start    = 1'b0;
   assign mid_sof      = 1'b0;
`endif

   // Before sync every offered pixel is swallowed (hunting for SOF)
   assign pix_ready_o = en_i && (take_ok || !synced);

   assign src_step  = (pix_hs && synced && !mid_sof) || sof_start;
   assign pad_step  = en_i && pad_q && room && more;
   assign step      = src_step || pad_step;
   assign step_data = pad_q ? '0 : pix_data_i;
   assign final_pix = have_low_q && (beat_cnt_q == LAST_BEAT);

   assign short_o   = (src_step && pix_last_i && !final_pix) || mid_sof;
   assign beat_hs   = out_valid_q && beat_ready_i;
   assign done_o    = beat_hs && out_last_q;

   assign beat_valid_o = out_valid_q;
   assign beat_last_o  = out_last_q;
   assign beat_data_o  = out_data_q;

   always_ff @(posedge aclk or posedge rst) begin
      if (rst) begin
         beat_cnt_q  <= '0;
         have_low_q  <= 1'b0;
         low_q       <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
         pad_q       <= 1'b0;
      end else if (!en_i) begin
         beat_cnt_q  <= '0;
         have_low_q  <= 1'b0;
         low_q       <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
         pad_q       <= 1'b0;
      end else begin
         if (beat_hs) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
         end
         // A pair only completes when the beat register is empty, so a load
         // and a handshake never coincide and stalled data is never touched.
         if (step) begin
            if (!have_low_q) begin
               low_q      <= step_data;
               have_low_q <= 1'b1;
            end else begin
               out_data_q  <= {step_data, low_q};
               out_valid_q <= 1'b1;
               out_last_q  <= (beat_cnt_q == LAST_BEAT);
               beat_cnt_q  <= beat_cnt_q + CW'(1);
               have_low_q  <= 1'b0;
            end
         end
         if (short_o) begin
            pad_q <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/display_framebuffer_writer.sv
// ---------------------------------------------------------------------------
// display_framebuffer_writer
// Captures one RGB565 frame into memory through the DSE st0 slave: sends a
// mem-write header, the framebuffer base address, then packed pixel beats.
// Optional feature macro: FB_WRITER_SOF_SYNC_EN (start-of-frame sync on tuser,
// implemented in the pixel packer).
// Ports:
//   aclk, rst     clock, asynchronous active-high reset
//   capture_fb    request one frame capture (accepted only when idle)
//   fb_addr       framebuffer base, latched on request accept
//   fb_captured   1 = idle / last frame fully handed over
//   frame_err     sticky short-frame flag, cleared on the next request
//   s_pix_axis    16 bit pixel stream (slave)
//   m_dse_axis    32 bit DSE command/data stream (master)
// ---------------------------------------------------------------------------
module display_framebuffer_writer
   import display_framebuffer_writer_pkg::*;
#(
   parameter int unsigned DISPLAY_SIZE_IN_BYTES = 320*480*2
) (
   input  logic                  aclk,
   input  logic                  rst,
   input  logic                  capture_fb,
   input  logic [ADDR_WIDTH-1:0] fb_addr,
   output logic                  fb_captured,
   output logic                  frame_err,
   display_framebuffer_writer_if.slave  s_pix_axis,
   display_framebuffer_writer_if.master m_dse_axis
);

   localparam int unsigned NUM_BEATS = DISPLAY_SIZE_IN_BYTES / 4;
   localparam logic [STREAM_WIDTH-1:0] HDR_WORD =
      dse_header(DSE_OP_MEM_WRITE, DSE_MUX_ST0, DSE_HDR_LEN_W'(DISPLAY_SIZE_IN_BYTES));

   fbw_state_e              state_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic                    hdr_valid_q;
   logic [STREAM_WIDTH-1:0] hdr_data_q;
   logic                    fb_captured_q;
   logic                    frame_err_q;

   logic                    pk_en;
   logic                    pk_valid;
   logic                    pk_last;
   logic [STREAM_WIDTH-1:0] pk_data;
   logic                    pk_short;
   logic                    pk_done;

   assign pk_en = (state_q == ST_DATA);

   display_framebuffer_writer_fb_pixel_packer #(
      .NUM_BEATS (NUM_BEATS)
   ) u_packer (
      .aclk         (aclk),
      .rst          (rst),
      .en_i         (pk_en),
      .pix_valid_i  (s_pix_axis.tvalid),
      .pix_ready_o  (s_pix_axis.tready),
      .pix_last_i   (s_pix_axis.tlast),
      .pix_user_i   (s_pix_axis.tuser),
      .pix_data_i   (s_pix_axis.tdata),
      .beat_ready_i (m_dse_axis.tready),
      .beat_valid_o (pk_valid),
      .beat_last_o  (pk_last),
      .beat_data_o  (pk_data),
      .short_o      (pk_short),
      .done_o       (pk_done)
   );

   // Header/address come from the FSM registers, data beats from the packer
   assign m_dse_axis.tvalid = pk_en ? pk_valid : hdr_valid_q;
   assign m_dse_axis.tdata  = pk_en ? pk_data  : hdr_data_q;
   assign m_dse_axis.tlast  = pk_en && pk_last;
   assign m_dse_axis.tuser  = 1'b0;

   assign fb_captured = fb_captured_q;
   assign frame_err   = frame_err_q;

   always_ff @(posedge aclk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         addr_q        <= '0;
         hdr_valid_q   <= 1'b0;
         hdr_data_q    <= '0;
         fb_captured_q <= 1'b1;
         frame_err_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (capture_fb) begin
                  addr_q        <= fb_addr;
                  fb_captured_q <= 1'b0;
                  frame_err_q   <= 1'b0;
                  hdr_valid_q   <= 1'b1;
                  hdr_data_q    <= HDR_WORD;
                  state_q       <= ST_HDR;
               end
            end
            ST_HDR: begin
               if (m_dse_axis.tready) begin
                  hdr_data_q <= addr_q;
                  state_q    <= ST_ADDR;
               end
            end
            ST_ADDR: begin
               if (m_dse_axis.tready) begin
                  hdr_valid_q <= 1'b0;
                  hdr_data_q  <= '0;
                  state_q     <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (pk_short) begin
                  frame_err_q <= 1'b1;
               end
               if (pk_done) begin
                  fb_captured_q <= 1'b1;
                  state_q       <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_display_framebuffer_writer.sv
// ---------------------------------------------------------------------------
// tb_display_framebuffer_writer
// Scoreboard bench for display_framebuffer_writer with a 16 byte frame.
// Expected DSE beats are queued when a capture is requested and compared as
// the DUT hands them over.
// ---------------------------------------------------------------------------
module tb_display_framebuffer_writer;

   localparam int SIZE = 16;
   localparam int NPIX = SIZE / 2;
   localparam int NBEATS = SIZE / 4;
`ifdef FB_WRITER_SOF_SYNC_EN
   localparam bit SOF = 1'b1;
`else
   localparam bit SOF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        capture_fb = 1'b0;
   logic [31:0] fb_addr = 32'h0;
   logic        fb_captured;
   logic        frame_err;

   display_framebuffer_writer_if #(.DW(16)) pix_if ();
   display_framebuffer_writer_if #(.DW(32)) dse_if ();

   display_framebuffer_writer #(
      .DISPLAY_SIZE_IN_BYTES (SIZE)
   ) dut (
      .aclk        (clk),
      .rst         (rst),
      .capture_fb  (capture_fb),
      .fb_addr     (fb_addr),
      .fb_captured (fb_captured),
      .frame_err   (frame_err),
      .s_pix_axis  (pix_if.slave),
      .m_dse_axis  (dse_if.master)
   );

   always #5 clk = ~clk;

   int          vec_cnt = 0;
   int          err_cnt = 0;
   logic [32:0] sbq[$];          // {tlast, tdata}
   bit          rand_ready = 1'b0;
   bit          last_seen = 1'b0;
   bit          stall_q = 1'b0;
   logic [32:0] stall_d = '0;

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // DSE sink ready
   always @(posedge clk) begin
      #1;
      dse_if.tready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
   end

   // Output monitor: handshakes, hold-while-stalled, idle after last beat
   always @(negedge clk) begin
      if (rst) begin
         stall_q   <= 1'b0;
         last_seen <= 1'b0;
      end else begin
         if (last_seen) begin
            check_vec("captured_after_last", {31'd0, fb_captured}, 32'd1);
            last_seen <= 1'b0;
         end
         if (stall_q) begin
            check_vec("hold_valid", {31'd0, dse_if.tvalid}, 32'd1);
            check_vec("hold_data", dse_if.tdata, stall_d[31:0]);
            check_vec("hold_last", {31'd0, dse_if.tlast}, {31'd0, stall_d[32]});
         end
         if (dse_if.tvalid && dse_if.tready) begin
            $display("beat data=%h last=%b", dse_if.tdata, dse_if.tlast);
            if (sbq.size() == 0) begin
               check_vec("extra_beat", dse_if.tdata, 32'hxxxx_xxxx);
            end else begin
               check_vec("beat_data", dse_if.tdata, sbq[0][31:0]);
               check_vec("beat_last", {31'd0, dse_if.tlast}, {31'd0, sbq[0][32]});
               void'(sbq.pop_front());
               if (dse_if.tlast) last_seen <= 1'b1;
            end
            stall_q <= 1'b0;
         end else if (dse_if.tvalid) begin
            stall_q <= 1'b1;
            stall_d <= {dse_if.tlast, dse_if.tdata};
         end else begin
            stall_q <= 1'b0;
         end
      end
   end

   // Reference frame: header, address, then the pixels padded with zeros to
   // the frame size, two per beat with the even pixel in the low half.
   task automatic push_frame(input logic [31:0] addr, input logic [15:0] px[$]);
      logic [15:0] lo, hi;
      sbq.push_back({1'b0, 2'b10, 2'b11, 28'(SIZE)});
      sbq.push_back({1'b0, addr});
      for (int b = 0; b < NBEATS; b++) begin
         lo = (2*b     < px.size()) ? px[2*b]     : 16'h0000;
         hi = (2*b + 1 < px.size()) ? px[2*b + 1] : 16'h0000;
         sbq.push_back({(b == NBEATS - 1), hi, lo});
      end
   endtask

   task automatic request(input logic [31:0] addr);
      capture_fb = 1'b1;
      fb_addr    = addr;
      @(posedge clk); #1;
      capture_fb = 1'b0;
      fb_addr    = 32'hdead_beef;
      check_vec("hdr_latency", {31'd0, dse_if.tvalid}, 32'd1);
      check_vec("busy", {31'd0, fb_captured}, 32'd0);
      check_vec("err_clr", {31'd0, frame_err}, 32'd0);
   endtask

   task automatic send_pix(input logic [15:0] d, input logic last, input logic user, input int gap);
      int n;
      for (int i = 0; i < gap; i++) begin
         @(posedge clk); #1;
      end
      pix_if.tvalid = 1'b1;
      pix_if.tdata  = d;
      pix_if.tlast  = last;
      pix_if.tuser  = user;
      n = 0;
      @(negedge clk);
      while (!pix_if.tready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) check_vec("pix_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      pix_if.tvalid = 1'b0;
      pix_if.tlast  = 1'b0;
      pix_if.tuser  = 1'b0;
   endtask

   // Source tlast on the last listed pixel; tuser on the first under SOF sync
   task automatic send_frame(input logic [15:0] px[$], input int poke_idx, input int user_idx,
                             input bit gaps);
      for (int i = 0; i < px.size(); i++) begin
         send_pix(px[i], (i == px.size() - 1), (SOF && i == 0) || (!SOF && i == user_idx),
                  gaps ? int'($urandom_range(0, 2)) : 0);
         if (i == poke_idx) begin
            capture_fb = 1'b1;
            fb_addr    = 32'h0bad_0000;
            @(posedge clk); #1;
            capture_fb = 1'b0;
         end
      end
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      @(negedge clk);
      while (!fb_captured && n < 400) begin
         @(negedge clk);
         n++;
      end
      check_vec(tag, {31'd0, fb_captured}, 32'd1);
      check_vec("sb_drained", sbq.size(), 32'd0);
      @(posedge clk); #1;
   endtask

   logic [15:0] px[$];

   initial begin
      pix_if.tvalid = 1'b0;
      pix_if.tlast  = 1'b0;
      pix_if.tuser  = 1'b0;
      pix_if.tdata  = 16'h0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_vec("rst_captured", {31'd0, fb_captured}, 32'd1);
      check_vec("rst_err", {31'd0, frame_err}, 32'd0);
      check_vec("rst_pix_ready", {31'd0, pix_if.tready}, 32'd0);
      check_vec("rst_tvalid", {31'd0, dse_if.tvalid}, 32'd0);
      check_vec("rst_tlast", {31'd0, dse_if.tlast}, 32'd0);
      check_vec("rst_tdata", dse_if.tdata, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Full frame, no backpressure
      rand_ready = 1'b0;
      px = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
      push_frame(32'h0010_0000, px);
      request(32'h0010_0000);
      send_frame(px, -1, -1, 1'b0);
      wait_idle("t1_idle");
      check_vec("t1_err", {31'd0, frame_err}, 32'd0);

      // Random gaps on both sides; capture_fb poked mid-frame must be ignored
      rand_ready = 1'b1;
      push_frame(32'h0020_0040, px);
      request(32'h0020_0040);
      send_frame(px, 2, 3, 1'b1);
      wait_idle("t2_idle");
      check_vec("t2_err", {31'd0, frame_err}, 32'd0);

      // Pixel offered while idle stays unconsumed
      pix_if.tvalid = 1'b1;
      pix_if.tdata  = 16'd9;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_vec("idle_pix_ready", {31'd0, pix_if.tready}, 32'd0);
         check_vec("idle_tvalid", {31'd0, dse_if.tvalid}, 32'd0);
      end
      @(posedge clk); #1;
      pix_if.tvalid = 1'b0;

      // Short frame: tlast on pixel 5
      rand_ready = 1'b0;
      px = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
      push_frame(32'h0030_0000, px);
      request(32'h0030_0000);
      send_frame(px, -1, -1, 1'b0);
      wait_idle("t3_idle");
      check_vec("t3_err", {31'd0, frame_err}, 32'd1);

      // Reset in the middle of DATA
      px = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
      push_frame(32'h0040_0000, px);
      request(32'h0040_0000);
      send_pix(16'd1, 1'b0, SOF, 0);
      send_pix(16'd2, 1'b0, 1'b0, 0);
      send_pix(16'd3, 1'b0, 1'b0, 0);
      @(negedge clk); #2;
      rst = 1'b1;
      #1;
      check_vec("mid_rst_captured", {31'd0, fb_captured}, 32'd1);
      check_vec("mid_rst_err", {31'd0, frame_err}, 32'd0);
      check_vec("mid_rst_pix_ready", {31'd0, pix_if.tready}, 32'd0);
      check_vec("mid_rst_tvalid", {31'd0, dse_if.tvalid}, 32'd0);
      check_vec("mid_rst_tlast", {31'd0, dse_if.tlast}, 32'd0);
      check_vec("mid_rst_tdata", dse_if.tdata, 32'd0);
      sbq.delete();
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // Fresh request after reset restarts at the header
      rand_ready = 1'b1;
      px = '{16'h11, 16'h12, 16'h13, 16'h14, 16'h15, 16'h16, 16'h17, 16'h18};
      push_frame(32'h0050_0000, px);
      request(32'h0050_0000);
      send_frame(px, -1, -1, 1'b1);
      wait_idle("t5_idle");
      check_vec("t5_err", {31'd0, frame_err}, 32'd0);

`ifdef FB_WRITER_SOF_SYNC_EN
      // Pixels before SOF are discarded
      rand_ready = 1'b0;
      px = '{16'd7, 16'd8, 16'd9, 16'd10, 16'd11, 16'd12, 16'd13, 16'd14};
      push_frame(32'h0060_0000, px);
      request(32'h0060_0000);
      send_pix(16'd3, 1'b0, 1'b0, 0);
      send_pix(16'd4, 1'b0, 1'b0, 0);
      send_pix(16'd5, 1'b0, 1'b0, 0);
      send_frame(px, -1, -1, 1'b0);
      wait_idle("t6_idle");
      check_vec("t6_err", {31'd0, frame_err}, 32'd0);
`endif

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
